// File: rtl/tea_arb.sv
// Round-robin arbiter sharing one 4-phase tinyenc/tinydec engine between two requesters.
// Optional engine-ack watchdog is enabled by defining TEA_ARB_TIMEOUT_EN.
module tea_arb #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata,
   output logic        err,
   output logic        eng_req,
   output logic [31:0] eng_wdata,
   input  logic        eng_ack,
   input  logic [31:0] eng_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ENG_HI = 2'd1;
   localparam logic [1:0] ENG_LO = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // Watchdog fires at the end of the TIMEOUT-th cycle spent in ENG_HI/ENG_LO.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   logic [1:0] state;
   logic       winner;
   logic       last;
   logic       pick;
   logic       win_req;
   logic       tmo;

   // On a tie the port not served last wins; a lone request always wins.
   assign pick    = req1 & (~req0 | ~last);
   assign win_req = winner ? req1 : req0;

`ifdef TEA_ARB_TIMEOUT_EN
   logic [15:0] cnt;
   logic        err_q;

   assign tmo = (cnt == TMO_LAST) &&
                ((state == ENG_HI && !eng_ack) || (state == ENG_LO && eng_ack));
   assign err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 16'd0;
         err_q <= 1'b0;
      end else begin
         if (state == IDLE || (state == ENG_HI && eng_ack)) begin
            cnt <= 16'd0;
         end else if (state == ENG_HI || state == ENG_LO) begin
            cnt <= cnt + 16'd1;
         end else begin
            cnt <= cnt;
         end
         if (tmo) begin
            err_q <= 1'b1;
         end else if (state == DONE && !win_req) begin
            err_q <= 1'b0;
         end else begin
            err_q <= err_q;
         end
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TMO_LAST;
   assign tmo            = 1'b0;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         winner    <= 1'b0;
         last      <= 1'b1;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         eng_req   <= 1'b0;
         rdata     <= 32'd0;
         eng_wdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               // A stale engine ack (e.g. left over from a reset) blocks new grants.
               if ((req0 || req1) && !eng_ack) begin
                  winner    <= pick;
                  eng_wdata <= pick ? wdata1 : wdata0;
                  eng_req   <= 1'b1;
                  state     <= ENG_HI;
               end
            end
            ENG_HI: begin
               if (eng_ack) begin
                  rdata   <= eng_rdata;
                  eng_req <= 1'b0;
                  state   <= ENG_LO;
               end else if (tmo) begin
                  eng_req <= 1'b0;
                  rdata   <= 32'd0;
                  ack0    <= ~winner;
                  ack1    <= winner;
                  state   <= DONE;
               end
            end
            ENG_LO: begin
               if (!eng_ack || tmo) begin
                  if (tmo) begin
                     rdata <= 32'd0;
                  end
                  ack0  <= ~winner;
                  ack1  <= winner;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!win_req) begin
                  ack0  <= 1'b0;
                  ack1  <= 1'b0;
                  last  <= winner;
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               eng_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tea_arb.sv
// Directed, table-driven bench for tea_arb; the engine handshake is played by the bench itself.
module tb_tea_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic [31:0] rdata;
   logic        err;
   logic        eng_req;
   logic [31:0] eng_wdata;
   logic        eng_ack;
   logic [31:0] eng_rdata;

   int total = 0;
   int bad   = 0;

   tea_arb #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .err(err),
      .eng_req(eng_req), .eng_wdata(eng_wdata),
      .eng_ack(eng_ack), .eng_rdata(eng_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r0;
      logic        r1;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] rd_a;
      logic [31:0] rd_b;
      int          dly;
      logic        first;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Acks must never overlap.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         total++;
         if (ack0 && ack1) begin
            bad++;
            $display("FAIL ack_exclusive: got ack0=%b ack1=%b expected at most one", ack0, ack1);
         end
      end
   end

   // Full 4-phase service of port p, expected to be granted on the next edge.
   task automatic serve(input logic p, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input logic rearm);
      @(negedge clk);
      chk("eng_req_rise", eng_req, 1);
      chk("eng_wdata_latch", eng_wdata, wd);
      if (p) wdata1 = ~wd; else wdata0 = ~wd;
      repeat (dly) @(negedge clk);
      chk("eng_req_held", eng_req, 1);
      chk("no_ack_early", {ack1, ack0}, 0);
      eng_rdata = rd;
      eng_ack   = 1'b1;
      @(negedge clk);
      chk("eng_req_fall", eng_req, 0);
      chk("no_ack_in_lo", {ack1, ack0}, 0);
      eng_ack   = 1'b0;
      eng_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ack_winner", p ? ack1 : ack0, 1);
      chk("ack_loser", p ? ack0 : ack1, 0);
      chk("rdata", rdata, rd);
      chk("err_clear", err, 0);
      chk("eng_wdata_stable", eng_wdata, wd);
      if (p) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      chk("ack_release", p ? ack1 : ack0, 0);
      chk("rdata_hold", rdata, rd);
      if (rearm) begin
         if (p) begin req1 = 1'b1; wdata1 = wd; end
         else begin req0 = 1'b1; wdata0 = wd; end
      end
   endtask

   initial begin
      logic flag;

      tbl[0] = '{1'b1, 1'b1, 32'h1111_0000, 32'h2222_0000, 32'hA000_0001, 32'hA000_0002, 3, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 32'h3333_0000, 32'h4444_0000, 32'hA000_0003, 32'hA000_0004, 0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 32'h5555_0000, 32'h6666_0000, 32'hA000_0005, 32'h0,        5, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 32'h7777_0000, 32'h8888_0000, 32'hA000_0006, 32'h0,        1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 32'h9999_0000, 32'hAAAA_0000, 32'hA000_0007, 32'h0,        2, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 32'hBBBB_0000, 32'hCCCC_0000, 32'hA000_0008, 32'h0,        2, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 32'hDDDD_0000, 32'hEEEE_0000, 32'hA000_0009, 32'hA000_000A, 4, 1'b0};

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wdata0 = 32'd0; wdata1 = 32'd0;
      eng_ack = 1'b0; eng_rdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_ack", {ack1, ack0}, 0);
      chk("rst_eng_req", eng_req, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_eng_wdata", eng_wdata, 0);
      rst = 1'b0;

      // Table rounds: ties resolve by pointer, lone requests win outright.
      for (int i = 0; i < 7; i++) begin
         wdata0 = tbl[i].w0; wdata1 = tbl[i].w1;
         req0 = tbl[i].r0; req1 = tbl[i].r1;
         serve(tbl[i].first, tbl[i].first ? tbl[i].w1 : tbl[i].w0, tbl[i].rd_a, tbl[i].dly, 1'b0);
         if (tbl[i].r0 && tbl[i].r1)
            serve(!tbl[i].first, tbl[i].first ? tbl[i].w0 : tbl[i].w1, tbl[i].rd_b, tbl[i].dly, 1'b0);
      end

      // Single transaction with a slow engine.
      wdata0 = 32'h7A30_4D21; req0 = 1'b1;
      serve(1'b0, 32'h7A30_4D21, 32'h1234_5678, 40, 1'b0);

      // Starvation: both requesters keep re-requesting; grants must alternate.
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      wdata0 = 32'h0000_00A0; wdata1 = 32'h0000_00B1; req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 8; i++)
         serve(i[0], i[0] ? 32'h0000_00B1 : 32'h0000_00A0, 32'hC000_0000 + i, 2, i < 6);

      // Reset while in ENG_HI, with the engine ack still high afterwards.
      wdata0 = 32'h0BAD_F00D; req0 = 1'b1;
      @(negedge clk);
      chk("midflight_eng_req", eng_req, 1);
      rst = 1'b1; eng_ack = 1'b1; eng_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("midrst_ack", {ack1, ack0}, 0);
      chk("midrst_eng_req", eng_req, 0);
      chk("midrst_err", err, 0);
      chk("midrst_rdata", rdata, 0);
      chk("midrst_eng_wdata", eng_wdata, 0);
      rst = 1'b0; req0 = 1'b0; req1 = 1'b1; wdata1 = 32'h600D_CAFE;
      repeat (3) @(negedge clk);
      chk("stale_ack_blocks", {eng_req, ack1, ack0}, 0);
      eng_ack = 1'b0;
      serve(1'b1, 32'h600D_CAFE, 32'h0F0F_0F0F, 3, 1'b0);

      // Engine that never acks.
      wdata0 = 32'h1357_9BDF; req0 = 1'b1;
      flag = 1'b0;
`ifdef TEA_ARB_TIMEOUT_EN
      repeat (16) begin
         @(negedge clk);
         if (!eng_req || ack0) flag = 1'b1;
      end
      chk("tmo_wait", flag, 0);
      @(negedge clk);
      chk("tmo_eng_req", eng_req, 0);
      chk("tmo_ack0", ack0, 1);
      chk("tmo_err", err, 1);
      chk("tmo_rdata", rdata, 0);
      req0 = 1'b0;
      @(negedge clk);
      chk("tmo_release", {err, ack0}, 0);
`else
      repeat (1000) begin
         @(negedge clk);
         if (!eng_req || ack0 || err) flag = 1'b1;
      end
      chk("no_tmo_wait", flag, 0);
      eng_rdata = 32'h2468_ACE0; eng_ack = 1'b1;
      @(negedge clk);
      chk("late_eng_req_fall", eng_req, 0);
      eng_ack = 1'b0;
      @(negedge clk);
      chk("late_ack0", ack0, 1);
      chk("late_rdata", rdata, 32'h2468_ACE0);
      req0 = 1'b0;
      @(negedge clk);
      chk("late_release", ack0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tea_arb.md
TEA_ARB -- requirements
Module: tea_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: engine-ack watchdog limit in clk cycles (range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1 each  requester 4-phase request.
REQ-005 SHALL have ports wdata0/wdata1  input  32 each  requester plaintext or ciphertext word.
REQ-006 SHALL have ports ack0/ack1  output  1 each  requester 4-phase acknowledge.
REQ-007 SHALL have port rdata  output  32  result word, shared by both requesters, valid while ack0 or ack1 is high.
REQ-008 SHALL have port err  output  1  high with ack when the transaction timed out.
REQ-009 SHALL have ports eng_req  output  1, eng_wdata  output  32  drive the engine's req and wdata.
REQ-010 SHALL have ports eng_ack  input  1, eng_rdata  input  32  from the engine's ack and rdata.

Function
REQ-011 SHALL share one tinyenc/tinydec engine between two requesters through an FSM with states IDLE, ENG_HI, ENG_LO and DONE.
REQ-012 IDLE: if either reqN=1, SHALL select a winner, latch its wdataN into eng_wdata, set eng_req=1, and move to ENG_HI; the transition is registered, so eng_req rises 1 cycle after reqN is sampled high.
REQ-013 Arbitration SHALL be round-robin: if both requesters are high, the port not served last wins; if only one is high, that port wins regardless of history.
REQ-014 ENG_HI: on eng_ack=1, SHALL capture eng_rdata into rdata, clear eng_req, and move to ENG_LO.
REQ-015 ENG_LO: on eng_ack=0, SHALL set ackN=1 for the winner and move to DONE.
REQ-016 DONE: on winner reqN=0, SHALL clear ackN, update the last-served pointer, and return to IDLE; the next grant is possible 1 cycle later.
REQ-017 eng_wdata SHALL stay stable from eng_req rise until the return to IDLE; wdataN changes after the latch SHALL be ignored.
REQ-018 The loser's request SHALL stay pending with its ack low, and SHALL be served on the next IDLE.
REQ-019 A reqN that drops before its grant SHALL be treated as withdrawn; a reqN that drops during ENG_HI or ENG_LO SHALL not abort the engine transaction.
REQ-020 At most one of ack0/ack1 SHALL be high at any time, and eng_req SHALL never be high outside ENG_HI.
REQ-021 rdata SHALL hold its last captured value while both acks are low.

Reset
REQ-022 With rst=1 at a clk edge, the FSM SHALL go to IDLE and ack0, ack1, eng_req, err, rdata and eng_wdata SHALL all be 0.
REQ-023 Reset SHALL set the last-served pointer to 1, so port 0 wins the first tie.
REQ-024 Reset mid-transaction SHALL abandon the transaction without an ack; an engine ack still high after reset SHALL be ignored until it returns low.
REQ-025 The block SHALL leave IDLE only on a reqN sampled while eng_ack=0.

Configuration
REQ-026 Macro TEA_ARB_TIMEOUT_EN, when defined, SHALL add a 16-bit counter that is cleared on entry to ENG_HI and ENG_LO and increments each cycle spent in them.
REQ-027 With the macro defined and the counter reaching TIMEOUT, the block SHALL clear eng_req, set rdata=0 and err=1, set ackN and go to DONE; err SHALL clear together with ackN.
REQ-028 Without the macro, the counter SHALL be absent, err SHALL be tied to 0, and the FSM SHALL wait on eng_ack indefinitely.

Verification
REQ-029 Scenario single: req0=1, wdata0=32'h7A30_4D21, model engine acks after 40 cycles with rdata 32'h1234_5678 -> eng_wdata=32'h7A30_4D21, then ack0=1 with rdata=32'h1234_5678 and err=0; ack0 clears 1 cycle after req0 drops.
REQ-030 Scenario tie: req0 and req1 raised in the same cycle after reset -> port 0 is served first, then port 1; a second tie is also served port 0 then port 1, because the pointer points at port 1 after the previous round.
REQ-031 Scenario starvation: req0 held continuously high with req1 high -> grants alternate 0,1,0,1 over 8 transactions.
REQ-032 Scenario reset mid-flight: rst pulsed for 1 cycle while in ENG_HI -> all outputs 0 the next cycle, no ack, and a fresh req1 is served normally.
REQ-033 Scenario timeout (TEA_ARB_TIMEOUT_EN, TIMEOUT=16): engine never acks -> eng_req falls and ack0=1, err=1, rdata=0 on the 16th cycle in ENG_HI; without the macro, ack0 stays 0 for 1000 cycles.
REQ-034 Scenario round trip: tea_arb in front of tinyenc, its rdata fed to tinydec through a second tea_arb, 200 random words with each byte in '0'..'z' -> decrypted word equals the input.
